mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and memory-stage
// requesters. Data normally wins, but under sustained contention the grant
// alternates so fetch cannot starve. Misaligned requests complete without a
// memory access; a wait counter bounds how long BUSY can stall on mem_ack.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0]    i_rdata,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  input  logic [2:0]               d_funct3,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     d_done,
  output logic                     stall_i,
  output logic                     stall_d,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic                     misalign_err,
  output logic                     timeout_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_grant_d;
  logic                     r_last_d;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt_inc;
  logic                     w_timeout_hit;
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [3:0]               r_mem_be;
  logic [DATA_WIDTH-1:0]    r_i_rdata;
  logic [DATA_WIDTH-1:0]    r_d_rdata;
  logic                     r_misalign_err;
  logic                     r_timeout_err;

  logic                     w_any_req;
  logic                     w_grant_d;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [3:0]               w_be;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic                     w_we;
  logic                     w_misalign;
  logic                     w_unused;

  // The sign-extension bit of funct3 only matters to the load consumer.
  assign w_unused  = d_funct3[2];

  assign w_any_req = i_req | d_req;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Arbitration and request decode: winner, byte enables, store lane data, alignment.
  always_comb begin
    w_grant_d  = d_req & ~(i_req & r_last_d);
    w_sel_addr = w_grant_d ? d_addr : i_addr;
    w_we       = w_grant_d & d_we;
    w_be       = 4'b1111;
    w_wdata    = '0;
    w_misalign = (w_sel_addr[1:0] != 2'b00);
    if (w_grant_d) begin
      w_wdata = d_wdata;
      case (d_funct3[1:0])
        2'b00: begin
          w_be       = 4'b0001 << d_addr[1:0];
          w_wdata    = {(DATA_WIDTH/8){d_wdata[7:0]}};
          w_misalign = 1'b0;
        end
        2'b01: begin
          w_be       = 4'b0011 << {d_addr[1], 1'b0};
          w_wdata    = {(DATA_WIDTH/16){d_wdata[15:0]}};
          w_misalign = d_addr[0];
        end
        default: ;
      endcase
    end
  end

  // Next-state logic plus state-decoded request and completion outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    mem_req       = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = w_misalign ? DONE : BUSY;
      end
      BUSY: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_nxt = DONE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_nxt   = DONE;
          w_timeout_hit = 1'b1;
        end
      end
      DONE: begin
        i_done      = ~r_grant_d;
        d_done      = r_grant_d;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant bookkeeping, latched memory fields, read data capture and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_d      <= 1'b0;
      r_last_d       <= 1'b0;
      r_cnt          <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_misalign_err <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_d   <= w_grant_d;
            r_last_d    <= w_grant_d;
            r_mem_we    <= w_we;
            r_mem_addr  <= {w_sel_addr[ADDRESS_WIDTH-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_be    <= w_be;
            r_cnt       <= '0;
            if (w_misalign) begin
              r_misalign_err <= 1'b1;
              if (w_grant_d) r_d_rdata <= '0;
              else           r_i_rdata <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (r_grant_d) r_d_rdata <= mem_rdata;
            else           r_i_rdata <= mem_rdata;
          end else if (w_timeout_hit) begin
            r_timeout_err <= 1'b1;
            if (r_grant_d) r_d_rdata <= '0;
            else           r_i_rdata <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  assign misalign_err = r_misalign_err;
  assign timeout_err  = r_timeout_err;
  assign stall_i      = i_req & ~i_done;
  assign stall_d      = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions checked against a
// transaction-level model of the arbiter (access size arithmetic, grant
// history, sticky error flags, expected timing per transaction).
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [2:0]    d_funct3;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic          i_done, d_done, stall_i, stall_d, mem_req, mem_we;
  logic          misalign_err, timeout_err;

  int checks   = 0;
  int failures = 0;
  bit m_last_d = 1'b0;
  bit m_mis    = 1'b0;
  bit m_to     = 1'b0;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_rdata(d_rdata), .d_done(d_done),
    .stall_i(stall_i), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes: fetches are words, data uses funct3[1:0].
  function automatic int acc_size(input bit is_d, input logic [2:0] f3);
    return is_d ? (1 << f3[1:0]) : 4;
  endfunction

  function automatic logic [3:0] exp_be(input int size, input logic [31:0] a);
    int v;
    v = ((1 << size) - 1) << int'(a % 32'd4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] w;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    w = '0;
    for (int k = 0; k < 4 / size; k++) w = w | ((wd & mask) << (8 * size * k));
    return w;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
    chk({tag, "_i_rdata"},   i_rdata,        32'd0);
    chk({tag, "_d_rdata"},   d_rdata,        32'd0);
    chk({tag, "_done"},      32'({i_done, d_done}), 32'd0);
    chk({tag, "_errs"},      32'({misalign_err, timeout_err}), 32'd0);
  endtask

  // Serve one grant to the expected winner: check the issued request, answer
  // with mem_ack after 'delay' request cycles, check completion, then drop the
  // winner's request while a stray ack is presented outside BUSY.
  task automatic serve(input string tag, input bit exp_d, input int delay, input logic [31:0] rv);
    logic [31:0] a;
    logic [31:0] exp_rd;
    int          size, exp_cyc, reqcyc, done_at;
    bit          mis, to, seen;
    a       = exp_d ? d_addr : i_addr;
    size    = acc_size(exp_d, d_funct3);
    mis     = (a % size) != 0;
    to      = !mis && (delay >= TO);
    exp_cyc = mis ? 0 : (to ? TO : delay + 1);
    exp_rd  = (mis || to) ? 32'd0 : rv;
    reqcyc  = 0;
    done_at = 0;
    seen    = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        reqcyc++;
        if (reqcyc == 1) begin
          chk({tag, "_addr"}, mem_addr, a & ~32'd3);
          chk({tag, "_be"}, 32'(mem_be), 32'(exp_be(size, a)));
          chk({tag, "_we"}, 32'(mem_we), 32'(exp_d & d_we));
          if (exp_d && d_we) chk({tag, "_wdata"}, mem_wdata, exp_wdata(size, d_wdata));
        end
        mem_ack   = (reqcyc - 1 == delay);
        mem_rdata = (reqcyc - 1 == delay) ? rv : $urandom();
      end else begin
        mem_ack = 1'b0;
      end
      if (i_done === 1'b1 || d_done === 1'b1) begin
        seen    = 1'b1;
        done_at = c;
      end
    end
    mem_ack = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    m_last_d = exp_d;
    m_mis    = m_mis | mis;
    m_to     = m_to | to;
    if (seen) begin
      chk({tag, "_winner"}, 32'({i_done, d_done}), 32'({!exp_d, exp_d}));
      chk({tag, "_reqcycles"}, 32'(reqcyc), 32'(exp_cyc));
      if (mis) chk({tag, "_mis_latency_ok"}, 32'(done_at <= 2), 32'd1);
      else     chk({tag, "_latency"}, 32'(done_at), 32'(exp_cyc + 1));
      chk({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, exp_rd);
      chk({tag, "_errs"}, 32'({misalign_err, timeout_err}), 32'({m_mis, m_to}));
      chk({tag, "_stall"}, 32'({stall_i, stall_d}),
          32'({exp_d ? i_req : 1'b0, exp_d ? 1'b0 : d_req}));
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = $urandom();
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, "_hold"}, exp_d ? d_rdata : i_rdata, exp_rd);
      chk({tag, "_nodone"}, 32'({i_done, d_done}), 32'd0);
      chk({tag, "_stall_after"}, 32'({stall_i, stall_d}), 32'({i_req, d_req}));
    end
  endtask

  task automatic set_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    d_we     = we;
    d_addr   = a;
    d_wdata  = wd;
    d_funct3 = f3;
    d_req    = 1'b1;
  endtask

  task automatic rand_fields();
    int          sz;
    logic [31:0] r;
    d_funct3 = 3'($urandom_range(0, 2));
    d_we     = 1'($urandom_range(0, 1));
    d_wdata  = $urandom();
    sz       = acc_size(1'b1, d_funct3);
    r        = $urandom();
    if ($urandom_range(0, 3) != 0) r = r & ~32'(sz - 1);
    d_addr   = r;
    r        = $urandom();
    if ($urandom_range(0, 3) != 0) r = r & ~32'd3;
    i_addr   = r;
  endtask

  initial begin
    bit w;
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_funct3 = 3'd0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_stall", 32'({stall_i, stall_d}), 32'd0);
    rst = 1'b0;

    // Fetch only at 0x100, acked on the fourth request cycle.
    i_addr = 32'h100;
    i_req  = 1'b1;
    serve("fetch", 1'b0, 3, 32'h00A0_0093);

    // Contention: first round data wins, then fetch; a second round repeats it.
    for (int r = 0; r < 2; r++) begin
      set_d(1'b0, 32'h300, 32'h0, 3'b010);
      i_addr = 32'h104;
      i_req  = 1'b1;
      serve("cont_first", 1'b1, 1, $urandom());
      serve("cont_second", 1'b0, 0, $urandom());
    end

    // After a lone data grant, contention goes to fetch.
    set_d(1'b1, 32'h208, 32'h1234_5678, 3'b010);
    serve("sw_alone", 1'b1, 2, $urandom());
    set_d(1'b0, 32'h20C, 32'h0, 3'b010);
    i_addr = 32'h108;
    i_req  = 1'b1;
    serve("alt_fetch", 1'b0, 0, $urandom());
    serve("alt_data", 1'b1, 0, $urandom());

    // SB to 0x203.
    set_d(1'b1, 32'h203, 32'h0000_00AB, 3'b000);
    serve("sb", 1'b1, 1, $urandom());

    // SW misaligned: no memory access, sticky error.
    set_d(1'b1, 32'h202, 32'hDEAD_BEEF, 3'b010);
    serve("sw_mis", 1'b1, 0, $urandom());

    // No ack: timeout after TO request cycles.
    set_d(1'b0, 32'h210, 32'h0, 3'b010);
    serve("timeout", 1'b1, 99, $urandom());

    // Reset in the middle of an access.
    set_d(1'b0, 32'h400, 32'h0, 3'b010);
    @(negedge clk);
    chk("rstbusy_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    m_last_d = 1'b0;
    m_mis    = 1'b0;
    m_to     = 1'b0;
    @(negedge clk);
    chk("rst_nodone", 32'({i_done, d_done}), 32'd0);
    rst = 1'b0;
    serve("after_rst", 1'b1, 1, $urandom());

    // Randomized mix of lone and contending requests.
    for (int n = 0; n < 30; n++) begin
      rand_fields();
      case ($urandom_range(0, 2))
        0: begin
          i_req = 1'b1;
          serve("rnd_fetch", 1'b0, $urandom_range(0, TO), $urandom());
        end
        1: begin
          d_req = 1'b1;
          serve("rnd_data", 1'b1, $urandom_range(0, TO), $urandom());
        end
        default: begin
          i_req = 1'b1;
          d_req = 1'b1;
          w = !m_last_d;
          serve("rnd_cont_a", w, $urandom_range(0, TO), $urandom());
          serve("rnd_cont_b", !w, $urandom_range(0, TO), $urandom());
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
